opsel_pipe: RTL and testbench
=============================

# opsel_pipe

Parametrised, registered operand-select stage for the ALU datapath. It picks one of `NUM_SRC` `DATA_W`-bit sources using a binary select and registers the result behind a valid/ready handshake, so the operand path can stall and be flushed cycle-accurately. Out-of-range selects yield zero. It sits between register-file/immediate sources and the ALU operand register.

## Interface
Parameters:
- `DATA_W`, 8: operand width in bits.
- `NUM_SRC`, 3: number of sources. Must satisfy 2 ≤ `NUM_SRC` ≤ 2**`SEL_W`.
- `SEL_W`, 2: select width in bits.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `src`  in  `NUM_SRC`*`DATA_W`: packed sources; source i is `src[i*DATA_W +: DATA_W]`.
- `sel`  in  `SEL_W`: binary source index.
- `in_valid`  in  1: `src`/`sel` valid this cycle.
- `in_ready`  out  1: stage can accept this cycle.
- `flush`  in  1: synchronous discard of all buffered operands.
- `out_data`  out  `DATA_W`: registered selected operand.
- `out_valid`  out  1: `out_data` valid.
- `out_ready`  in  1: consumer takes `out_data` this cycle.
- `sel_err`  out  1: sticky flag; set when an out-of-range `sel` is accepted.

## Operation
- Accept occurs on a rising edge when `in_valid && in_ready && !flush`.
- Produce occurs on a rising edge when `out_valid && out_ready`.
- Select rule:
  - If `sel` < `NUM_SRC`, the selected value is source `sel`.
  - If `sel` ≥ `NUM_SRC`, the selected value is all zeros. This case still counts as a valid accept and sets `sel_err`.
- Data is captured at accept. Later changes to `src`/`sel` do not affect a held operand.
- `flush` has priority over accept and produce:
  - Next state is empty, `out_valid` goes to 0, and any concurrent input is dropped.
  - `sel_err` clears.
  - `out_data` is not cleared by a flush.
- `sel_err` is set by an accept with an out-of-range `sel`. It is cleared only by `flush` or reset. If a flush and an erroneous `in_valid` occur in the same cycle, the result is cleared.
- `out_data` holds its value while `out_valid && !out_ready`. No data is lost or duplicated.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `sel_err`=0, `in_ready`=1, internal state EMPTY.
- Reset is asynchronous assert. A mid-transfer reset drops all held operands immediately.
- Latency: an operand accepted at edge k appears with `out_valid`=1 after edge k.
- Throughput: one operand per cycle while `out_ready`=1.
- State machine (with `OPSEL_SKID_EN`): states EMPTY, ONE (main register valid), TWO (main and skid valid).
  - EMPTY + accept → ONE.
  - ONE + accept + produce → ONE, with main loaded from the new input.
  - ONE + accept + no produce → TWO, with the new input loaded into the skid register.
  - ONE + produce + no accept → EMPTY.
  - TWO + produce → ONE, with skid moved to main. No accept is possible in TWO.
  - Any state + `flush` → EMPTY.
- `out_valid` = state ≠ EMPTY.
- `in_ready` = state ≠ TWO. It is a registered decode and has no combinational path from `out_ready`.

## Configuration
- Macro: `OPSEL_SKID_EN`.
- Defined:
  - Two-entry skid buffer as described above.
  - `in_ready` has no combinational dependence on `out_ready`.
  - At most two operands are in flight.
- Undefined:
  - Single output register only. States EMPTY/ONE; TWO is unreachable.
  - `in_ready` = `!out_valid || out_ready` (combinational path from `out_ready`).
  - Latency and select behaviour are identical. Throughput is still one per cycle while `out_ready`=1.
  - Under backpressure, at most one operand is held.

## Test plan
- Reset and pass-through: `DATA_W`=8, `NUM_SRC`=3, `src`={C=0x33, B=0x22, A=0x11}, `out_ready`=1.
  - While `rst_n`=0: `out_valid`=0, `out_data`=0x00, `in_ready`=1.
  - Accepting sel=0, 1, 2 on consecutive edges gives out 0x11, 0x22, 0x33, one cycle later each, back-to-back.
- Out-of-range select: sel=3 is accepted.
  - Next cycle: `out_data`=0x00, `out_valid`=1, `sel_err`=1.
  - `sel_err` stays 1 through 5 further valid accepts, and clears after a single `flush` cycle.
- Backpressure (skid build): `out_ready`=0, accept sel=0 then sel=1.
  - With `OPSEL_SKID_EN`: `in_ready` falls to 0 after the 2nd accept. Raising `out_ready` drains 0x11 then 0x22 in order.
  - Without `OPSEL_SKID_EN`: `in_ready`=0 from the cycle after the 1st accept.
- Flush versus simultaneous accept: while in state TWO (or ONE), assert `flush` with `in_valid`=1, sel=2.
  - Next cycle: `out_valid`=0 and nothing is emitted afterwards.
  - 0x33 is never seen.
- Data capture: accept sel=1 with B=0x22 under `out_ready`=0, then change B to 0x99. `out_data` stays 0x22 until produced.
- Async reset mid-operation: in state TWO, pulse `rst_n` low between clock edges.
  - `out_valid`=0 and `in_ready`=1 immediately, before the next edge.
  - No stale operand appears after release.

Source files
------------

// File: rtl/opsel_pipe.sv
// opsel_pipe: registered operand-select stage for the ALU datapath.
// Picks one of NUM_SRC sources by binary select (out-of-range -> zero,
// sticky sel_err) and registers it behind a valid/ready handshake.
// Build option: define OPSEL_SKID_EN for a two-entry skid buffer with a
// registered in_ready; leave it undefined for a single output register.
module opsel_pipe #(
    parameter int DATA_W  = 8,
    parameter int NUM_SRC = 3,
    parameter int SEL_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC*DATA_W-1:0] src,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      flush,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      sel_err
);

    logic [DATA_W-1:0] sel_val;
    logic              sel_oor;
    logic              accept;
    logic              produce;
    logic              sel_err_q, sel_err_d;
    logic [DATA_W-1:0] main_q, main_d;

    // Select the addressed source; an index with no matching source yields zero.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        sel_val = '0;
        sel_oor = 1'b1;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_val = src[i*DATA_W +: DATA_W];
                sel_oor = 1'b0;
            end
        end
    end

    assign accept   = in_valid && in_ready && !flush;
    assign produce  = out_valid && out_ready;
    assign out_data = main_q;

    // Sticky error: set by an accepted out-of-range select, cleared only by flush.
    always_comb begin
        sel_err_d = sel_err_q;
        if (flush)
            sel_err_d = 1'b0;
        else if (accept && sel_oor)
            sel_err_d = 1'b1;
    end

    assign sel_err = sel_err_q;

`ifdef OPSEL_SKID_EN
    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] skid_q, skid_d;

    // Both handshake outputs decode the state register, so in_ready never
    // depends combinationally on out_ready.
    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = (state_q != ST_TWO);

    // Next-state and datapath loads for the main/skid pair; flush wins.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        main_d  = sel_val;
                    end
                end
                ST_ONE: begin
                    if (accept && produce) begin
                        main_d = sel_val;
                    end else if (accept) begin
                        state_d = ST_TWO;
                        skid_d  = sel_val;
                    end else if (produce) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (produce) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // State, operand registers and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            // NOTE: operand registers are reset as well because out_data must read zero out of reset.
            main_q    <= '0;
            skid_q    <= '0;
            sel_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            sel_err_q <= sel_err_d;
        end
    end
`else
    logic out_valid_q, out_valid_d;

    assign out_valid = out_valid_q;
    // A full register can still accept when it is being drained this cycle.
    assign in_ready  = !out_valid_q || out_ready;

    // Single output register: load on accept, empty on produce or flush.
    always_comb begin
        out_valid_d = out_valid_q;
        main_d      = main_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            main_d      = sel_val;
        end else if (produce) begin
            out_valid_d = 1'b0;
        end
    end

    // Valid flag, operand register and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            main_q      <= '0;
            sel_err_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            main_q      <= main_d;
            sel_err_q   <= sel_err_d;
        end
    end
`endif

endmodule

// File: tb/tb_opsel_pipe.sv
// Self-checking bench for opsel_pipe. A queue-based reference model holds
// the operands in flight (capacity 2 with OPSEL_SKID_EN, 1 without).
module tb_opsel_pipe;

    localparam int DATA_W  = 8;
    localparam int NUM_SRC = 3;
    localparam int SEL_W   = 2;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_SRC*DATA_W-1:0] src;
    logic [SEL_W-1:0]          sel;
    logic                      in_valid;
    logic                      in_ready;
    logic                      flush;
    logic [DATA_W-1:0]         out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic                      sel_err;

    opsel_pipe #(.DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst_n(rst_n), .src(src), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .sel_err(sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [DATA_W-1:0] src_arr [NUM_SRC];
    logic [DATA_W-1:0] model_q [$];
    logic [DATA_W-1:0] shown;
    logic              model_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] ref_sel(input int s);
        return (s < NUM_SRC) ? src_arr[s] : '0;
    endfunction

    function automatic logic model_ready(input logic ordy);
`ifdef OPSEL_SKID_EN
        return model_q.size() < 2;
`else
        return (model_q.size() == 0) || ordy;
`endif
    endfunction

    task automatic pack_src();
        for (int i = 0; i < NUM_SRC; i++) src[i*DATA_W +: DATA_W] = src_arr[i];
    endtask

    task automatic model_reset();
        model_q.delete();
        shown     = '0;
        model_err = 1'b0;
    endtask

    // One clock cycle: drive, check outputs against the model, advance both.
    task automatic step(input logic v, input logic [SEL_W-1:0] s, input logic fl, input logic ordy);
        logic              exp_ready, acc, prod, oor;
        logic [DATA_W-1:0] val;
        in_valid  = v;
        sel       = s;
        flush     = fl;
        out_ready = ordy;
        pack_src();
        #1;
        exp_ready = model_ready(ordy);
        check("in_ready",  32'(in_ready),  32'(exp_ready));
        check("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
        check("out_data",  32'(out_data),  32'(shown));
        check("sel_err",   32'(sel_err),   32'(model_err));
        acc  = v && exp_ready && !fl;
        prod = (model_q.size() != 0) && ordy;
        val  = ref_sel(int'(s));
        oor  = int'(s) >= NUM_SRC;
        @(posedge clk);
        if (fl) begin
            model_q.delete();
            model_err = 1'b0;
        end else begin
            if (prod) void'(model_q.pop_front());
            if (acc) begin
                model_q.push_back(val);
                if (oor) model_err = 1'b1;
            end
        end
        if (model_q.size() != 0) shown = model_q[0];
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        sel       = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        src_arr[0] = 8'h11;
        src_arr[1] = 8'h22;
        src_arr[2] = 8'h33;
        pack_src();
        model_reset();

        // Reset values while rst_n is low
        #3;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data",  32'(out_data),  32'(8'h00));
        check("rst_in_ready",  32'(in_ready),  32'(1));
        check("rst_sel_err",   32'(sel_err),   32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back pass-through
        step(1, 0, 0, 1);
        step(1, 1, 0, 1);
        step(1, 2, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // Out-of-range select, sticky error, cleared by one flush
        step(1, 3, 0, 1);
        check("oor_data",  32'(out_data),  32'(8'h00));
        check("oor_valid", 32'(out_valid), 32'(1));
        check("oor_err",   32'(sel_err),   32'(1));
        for (int i = 0; i < 5; i++) step(1, SEL_W'(i % NUM_SRC), 0, 1);
        check("err_sticky", 32'(sel_err), 32'(1));
        step(0, 0, 1, 1);
        step(0, 0, 0, 1);
        check("err_cleared", 32'(sel_err), 32'(0));

        // Backpressure: two accept attempts, then drain
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
`ifdef OPSEL_SKID_EN
        check("bp_in_ready_skid", 32'(in_ready), 32'(0));
`else
        check("bp_in_ready_reg", 32'(in_ready), 32'(0));
`endif
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // Flush with a concurrent accept drops everything, 0x33 never seen
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 2, 1, 0);
        check("flush_valid", 32'(out_valid), 32'(0));
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // Data captured at accept; later source change is ignored
        step(1, 1, 0, 0);
        src_arr[1] = 8'h99;
        step(0, 1, 0, 0);
        check("capture_hold", 32'(out_data), 32'(8'h22));
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        src_arr[1] = 8'h22;

        // Asynchronous reset between edges with operands held
        step(1, 0, 0, 0);
        step(1, 2, 0, 0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_out_valid", 32'(out_valid), 32'(0));
        check("areset_in_ready",  32'(in_ready),  32'(1));
        check("areset_out_data",  32'(out_data),  32'(8'h00));
        model_reset();
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0)
                for (int k = 0; k < NUM_SRC; k++) src_arr[k] = 8'($urandom);
            step(1'($urandom_range(0, 1)),
                 SEL_W'($urandom_range(0, 3)),
                 1'($urandom_range(0, 19) == 0),
                 1'((i / 40) % 2 == 0 ? $urandom_range(0, 4) != 0 : $urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
